// File: rtl/imem_port_arbiter_if.sv
// Request/response bundle for the fetch and loader ports of imem_port_arbiter.
// master = requester side, slave = arbiter side.
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              f_req;
  logic [31:0]       f_addr;
  logic              f_ack;
  logic [DATA_W-1:0] f_rdata;
  logic              f_err;
  logic              l_req;
  logic              l_we;
  logic [31:0]       l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_ack;
  logic [DATA_W-1:0] l_rdata;
  logic              l_err;

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata,
    input  f_ack, f_rdata, f_err, l_ack, l_rdata, l_err
  );
  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata,
    output f_ack, f_rdata, f_err, l_ack, l_rdata, l_err
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Round-robin fetch/loader arbiter and IDLE/ACCESS/RESP sequencer for the instruction memory.
// Optional address checking is enabled by defining IMEM_ARB_ADDR_CHECK_EN.
module imem_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_port_arbiter_if.slave   bus,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_we,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_nx;
  logic              last_l;   // 1: loader was granted last
  logic              port_q;   // 1: loader owns the current access
  logic              we_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, resp_q;

  logic              f_cand, l_cand, grant, grant_l, sel_err;
  logic [31:0]       sel_addr;

  // In RESP the port being acked is excluded so the other one can go straight to ACCESS.
  always_comb begin
    f_cand   = bus.f_req && (state == IDLE || (state == RESP && port_q));
    l_cand   = bus.l_req && (state == IDLE || (state == RESP && !port_q));
    grant_l  = l_cand && (!f_cand || !last_l);
    grant    = f_cand || l_cand;
    sel_addr = grant_l ? bus.l_addr : bus.f_addr;
  end

`ifdef IMEM_ARB_ADDR_CHECK_EN
  assign sel_err = (sel_addr[1:0] != 2'b00) || (sel_addr[31:ADDR_W+2] != '0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};
  assign sel_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = grant ? ACCESS : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last_l  <= 1'b1;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        addr_q <= sel_addr[ADDR_W+1:2];
        port_q <= grant_l;
        we_q   <= grant_l && bus.l_we && !sel_err;
        err_q  <= sel_err;
        last_l <= grant_l;
        if (grant_l) wdata_q <= bus.l_wdata;
      end
      // Read-before-write: the old word is captured in the same cycle the write strobes.
      if (state == ACCESS) resp_q <= err_q ? '0 : mem_rdata;
    end
  end

  logic in_resp;
  assign in_resp     = (state == RESP) && !rst;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_we      = (state == ACCESS) && we_q && !rst;
  assign busy        = (state != IDLE);
  assign bus.f_ack   = in_resp && !port_q;
  assign bus.l_ack   = in_resp && port_q;
  assign bus.f_rdata = bus.f_ack ? resp_q : '0;
  assign bus.l_rdata = bus.l_ack ? resp_q : '0;
`ifdef IMEM_ARB_ADDR_CHECK_EN
  assign bus.f_err   = bus.f_ack && err_q;
  assign bus.l_err   = bus.l_ack && err_q;
`else
  assign bus.f_err   = 1'b0;
  assign bus.l_err   = 1'b0;
`endif
endmodule
